// File: rtl/alu_pkg.sv
// Shared ALU definitions: AluOp encoding {funct7[5], funct3}, FSM states, op helpers.
package alu_pkg;

    typedef enum logic [3:0] {
        ALU_ADD  = 4'b0000,
        ALU_SLL  = 4'b0001,
        ALU_SLT  = 4'b0010,
        ALU_SLTU = 4'b0011,
        ALU_XOR  = 4'b0100,
        ALU_SRL  = 4'b0101,
        ALU_OR   = 4'b0110,
        ALU_AND  = 4'b0111,
        ALU_SUB  = 4'b1000,
        ALU_SRA  = 4'b1101
    } aluOpE;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } stateE;

    function automatic logic isShiftOp(input logic [3:0] op);
        return (op == ALU_SLL) || (op == ALU_SRL) || (op == ALU_SRA);
    endfunction

endpackage

// File: rtl/alu_shifter.sv
// Iterative one-bit-per-cycle shifter with start/busy/done; only used when
// ALU_BARREL_SHIFT_EN is undefined.
module alu_shifter #(
    parameter int WIDTH = 32
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       start,
    input  logic [WIDTH-1:0]           din,
    input  logic [$clog2(WIDTH)-1:0]   amount,
    input  logic                       shiftLeft,
    input  logic                       arith,
    output logic                       busy,
    output logic                       done,
    output logic [WIDTH-1:0]           result
);
    localparam int SHW = $clog2(WIDTH);

    logic [WIDTH-1:0] work;
    logic [SHW-1:0]   cnt;
    logic             leftR;
    logic             arithR;
    logic [WIDTH-1:0] step;

    // One-bit move of the working register; SRA replicates the sign bit.
    always_comb begin
        step = '0;
        if (leftR) step = {work[WIDTH-2:0], 1'b0};
        else       step = {arithR & work[WIDTH-1], work[WIDTH-1:1]};
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            work   <= '0;
            cnt    <= '0;
            leftR  <= 1'b0;
            arithR <= 1'b0;
        end else if (start) begin
            work   <= din;
            cnt    <= amount;
            leftR  <= shiftLeft;
            arithR <= arith;
        end else if (cnt != '0) begin
            work <= step;
            cnt  <= cnt - 1'b1;
        end
    end

    // done marks the cycle whose edge performs the final shift; result is that value.
    assign busy   = (cnt != '0);
    assign done   = (cnt == SHW'(1));
    assign result = step;

endmodule

// File: rtl/alu_iter.sv
// Handshaked multi-cycle ALU. Define ALU_BARREL_SHIFT_EN for single-cycle
// barrel shifts; otherwise shifts iterate one bit per cycle in alu_shifter.
module alu_iter
    import alu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic [3:0]       AluOp,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] S,
    output logic             illegal
);
    localparam int SHW = $clog2(WIDTH);

    // Handshake: a transfer happens on an edge where valid and ready are both
    // high; in_ready/out_valid are registered and only change on clock edges.
    stateE            state;
    aluOpE            op;
    logic [SHW-1:0]   amt;
    logic             accept;
    logic [WIDTH-1:0] shlRes;
    logic [WIDTH-1:0] shrRes;
    logic [WIDTH-1:0] sraRes;
    logic [WIDTH-1:0] aluRes;
    logic             aluIll;

    assign op     = aluOpE'(AluOp);
    assign amt    = B[SHW-1:0];
    assign accept = (state == ST_IDLE) && in_valid;

`ifdef ALU_BARREL_SHIFT_EN
    assign shlRes = A << amt;
    assign shrRes = A >> amt;
    assign sraRes = WIDTH'($signed(A) >>> amt);
`else
    // Only reached here for amount 0; non-zero amounts go through alu_shifter.
    assign shlRes = A;
    assign shrRes = A;
    assign sraRes = A;

    logic             shStart;
    logic             shBusy;
    logic             shDone;
    logic [WIDTH-1:0] shNext;

    assign shStart = accept && isShiftOp(AluOp) && (amt != '0);

    alu_shifter #(.WIDTH(WIDTH)) uShifter (
        .clk       (clk),
        .rst       (rst),
        .start     (shStart),
        .din       (A),
        .amount    (amt),
        .shiftLeft (op == ALU_SLL),
        .arith     (op == ALU_SRA),
        .busy      (shBusy),
        .done      (shDone),
        .result    (shNext)
    );
`endif

    always_comb begin
        aluRes = '0;
        aluIll = 1'b0;
        case (op)
            ALU_ADD:  aluRes = A + B;
            ALU_SUB:  aluRes = A - B;
            ALU_SLL:  aluRes = shlRes;
            ALU_SLT:  aluRes = {{(WIDTH-1){1'b0}}, $signed(A) < $signed(B)};
            ALU_SLTU: aluRes = {{(WIDTH-1){1'b0}}, A < B};
            ALU_XOR:  aluRes = A ^ B;
            ALU_SRL:  aluRes = shrRes;
            ALU_SRA:  aluRes = sraRes;
            ALU_OR:   aluRes = A | B;
            ALU_AND:  aluRes = A & B;
            default:  aluIll = 1'b1;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= ST_IDLE;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            S         <= '0;
            illegal   <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (accept) begin
                        in_ready <= 1'b0;
`ifndef ALU_BARREL_SHIFT_EN
                        if (shStart) begin
                            state <= ST_SHIFT;
                        end else
`endif
                        begin
                            state     <= ST_DONE;
                            out_valid <= 1'b1;
                            S         <= aluRes;
                            illegal   <= aluIll;
                        end
                    end
                end
`ifndef ALU_BARREL_SHIFT_EN
                ST_SHIFT: begin
                    if (shBusy && shDone) begin
                        state     <= ST_DONE;
                        out_valid <= 1'b1;
                        S         <= shNext;
                        illegal   <= 1'b0;
                    end
                end
`endif
                ST_DONE: begin
                    if (out_ready) begin
                        state     <= ST_IDLE;
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                    end
                end
                default: begin
                    state     <= ST_IDLE;
                    out_valid <= 1'b0;
                    in_ready  <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_alu_iter.sv
// Scoreboard bench for alu_iter: driver pushes model results, negedge monitor pops and compares.
module tb_alu_iter;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] A = '0;
    logic [31:0] B = '0;
    logic [3:0]  AluOp = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] S;
    logic        illegal;

    always #5 clk = ~clk;

    alu_iter #(.WIDTH(32)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .A         (A),
        .B         (B),
        .AluOp     (AluOp),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .S         (S),
        .illegal   (illegal)
    );

    int          checks = 0;
    int          fails = 0;
    int          outMode = 2;   // 0 random, 1 held low, 2 held high
    bit          dropMode = 1'b0;
    bit          seen = 1'b0;
    bit          chkReady = 1'b0;
    logic [31:0] expQ[$];
    logic        expIllQ[$];
    int          expLatQ[$];
    longint      accQ[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model from the opcode table, shifts done as multiply/divide by 2^k.
    function automatic void model(input logic [31:0] a, input logic [31:0] b, input logic [3:0] op,
                                  output logic [31:0] r, output logic ill, output int lat);
        int k;
        longint unsigned p;
        longint unsigned av;
        longint unsigned nav;
        k   = int'(b % 32);
        p   = 64'd1 << k;
        av  = {32'd0, a};
        nav = {32'd0, ~a};
        ill = 1'b0;
        lat = 1;
        r   = '0;
        case (op)
            4'b0000: r = a + b;
            4'b1000: r = a - b;
            4'b0010: r = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            4'b0011: r = (av < {32'd0, b}) ? 32'd1 : 32'd0;
            4'b0100: r = a ^ b;
            4'b0110: r = a | b;
            4'b0111: r = a & b;
            4'b0001: r = 32'(av * p);
            4'b0101: r = 32'(av / p);
            4'b1101: r = a[31] ? ~32'(nav / p) : 32'(av / p);
            default: begin r = '0; ill = 1'b1; end
        endcase
`ifndef ALU_BARREL_SHIFT_EN
        if ((op == 4'b0001 || op == 4'b0101 || op == 4'b1101) && k > 0) lat = k + 1;
`endif
    endfunction

    task automatic sendOp(input logic [31:0] a, input logic [31:0] b, input logic [3:0] op, input bit push);
        int          n;
        bit          ok;
        logic [31:0] r;
        logic        ill;
        int          lat;
        n  = 0;
        ok = 1'b0;
        A = a; B = b; AluOp = op; in_valid = 1'b1;
        while (n < 500 && !ok) begin
            @(negedge clk);
            if (in_ready) ok = 1'b1;
            else n++;
        end
        if (!ok) begin
            checks++; fails++;
            $display("FAIL accept_timeout: in_ready low for %0d cycles, required high", n);
            in_valid = 1'b0;
            return;
        end
        @(posedge clk);
        if (push) begin
            model(a, b, op, r, ill, lat);
            expQ.push_back(r);
            expIllQ.push_back(ill);
            expLatQ.push_back(lat);
            accQ.push_back(longint'($time));
        end
        #1 in_valid = 1'b0;
    endtask

    task automatic waitDrain();
        int n;
        n = 0;
        while (expQ.size() != 0 && n < 3000) begin
            @(posedge clk);
            n++;
        end
        if (expQ.size() != 0) begin
            checks++; fails++;
            $display("FAIL drain_timeout: %0d results outstanding, required 0", expQ.size());
        end
    endtask

    initial begin
        forever begin
            @(posedge clk);
            #1;
            case (outMode)
                0:       out_ready = ($urandom_range(0, 3) != 0);
                1:       out_ready = 1'b0;
                default: out_ready = 1'b1;
            endcase
        end
    end

    always @(negedge clk) begin
        if (!rst && !dropMode) begin
            if (chkReady) begin
                check("in_ready_after_consume", {31'd0, in_ready}, 32'd1);
                chkReady = 1'b0;
            end
            if (out_valid) begin
                if (expQ.size() == 0) begin
                    checks++; fails++;
                    $display("FAIL spurious_out_valid: got S=%h with no outstanding op", S);
                end else begin
                    if (!seen) begin
                        seen = 1'b1;
                        check("latency", 32'((longint'($time) - accQ[0] + 5) / 10), 32'(expLatQ[0]));
                    end
                    check("result_S", S, expQ[0]);
                    check("illegal", {31'd0, illegal}, {31'd0, expIllQ[0]});
                    check("in_ready_while_done", {31'd0, in_ready}, 32'd0);
                    if (out_ready) begin
                        void'(expQ.pop_front());
                        void'(expIllQ.pop_front());
                        void'(expLatQ.pop_front());
                        void'(accQ.pop_front());
                        seen = 1'b0;
                        chkReady = 1'b1;
                    end
                end
            end
        end
    end

    initial begin
        logic [31:0] ra;
        logic [31:0] rb;
        @(negedge clk);
        check("reset_in_ready", {31'd0, in_ready}, 32'd1);
        check("reset_out_valid", {31'd0, out_valid}, 32'd0);
        check("reset_S", S, 32'd0);
        check("reset_illegal", {31'd0, illegal}, 32'd0);
        @(posedge clk);
        #1 rst = 1'b0;

        sendOp(32'd8, 32'd4, 4'b0000, 1'b1);
        sendOp(32'd8, 32'd4, 4'b1000, 1'b1);
        sendOp(32'hFFFF_FFFF, 32'd1, 4'b0010, 1'b1);
        sendOp(32'hFFFF_FFFF, 32'd1, 4'b0011, 1'b1);
        sendOp(32'h8000_0000, 32'd4, 4'b1101, 1'b1);
        sendOp(32'h8000_0000, 32'd4, 4'b0101, 1'b1);
        sendOp(32'd1, 32'h25, 4'b0001, 1'b1);
        sendOp(32'h1234_5678, 32'hFFFF_FFE0, 4'b1101, 1'b1);
        sendOp(32'h8765_4321, 32'd31, 4'b1101, 1'b1);
        sendOp(32'hDEAD_BEEF, 32'hCAFE_F00D, 4'b1111, 1'b1);
        waitDrain();

        // Backpressure: result must hold while out_ready stays low.
        outMode = 1;
        sendOp(32'h0000_00FF, 32'h0000_0F00, 4'b0110, 1'b1);
        repeat (10) @(posedge clk);
        outMode = 2;
        waitDrain();

        // Reset in the middle of a 20-bit shift.
        dropMode = 1'b1;
        outMode  = 1;
        sendOp(32'h0000_0003, 32'd20, 4'b0001, 1'b0);
        repeat (7) @(posedge clk);
        #1 rst = 1'b1;
        #1;
        check("midreset_out_valid", {31'd0, out_valid}, 32'd0);
        check("midreset_S", S, 32'd0);
        check("midreset_illegal", {31'd0, illegal}, 32'd0);
        check("midreset_in_ready", {31'd0, in_ready}, 32'd1);
        @(posedge clk);
        #1 rst = 1'b0;
        dropMode = 1'b0;
        outMode  = 2;
        sendOp(32'd100, 32'd23, 4'b0000, 1'b1);
        waitDrain();

        outMode = 0;
        for (int i = 0; i < 60; i++) begin
            ra = $urandom;
            rb = ($urandom_range(0, 1) == 0) ? 32'($urandom_range(0, 40)) : $urandom;
            sendOp(ra, rb, 4'($urandom_range(0, 15)), 1'b1);
        end
        outMode = 2;
        waitDrain();
        repeat (2) @(posedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
